// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller / cache memory pair.
// Holds the state encoding, the default geometry and the width-derivation helpers.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        REFILL
    } cache_state_e;

    localparam int DEF_WORD_SIZE       = 32;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_NUM_BLOCKS      = 64;
    localparam int DEF_NUM_WAYS        = 4;
    localparam int DEF_ADDR_WIDTH      = 32;

    function automatic int sets_of(input int num_blocks, input int num_ways);
        return num_blocks / num_ways;
    endfunction

    function automatic int offset_width(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_width(input int num_blocks, input int num_ways);
        return $clog2(sets_of(num_blocks, num_ways));
    endfunction

    function automatic int tag_width(input int addr_width, input int num_blocks,
                                     input int num_ways, input int words_per_block);
        return addr_width - index_width(num_blocks, num_ways) - offset_width(words_per_block);
    endfunction

endpackage

// File: rtl/cache_addr_split.sv
// Pure field extraction of a word address into {tag, index, offset}; offset sits in the LSBs.
module cache_addr_split #(
    parameter int ADDR_WIDTH   = 32,
    parameter int TAG_WIDTH    = 26,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    output logic [TAG_WIDTH-1:0]    tag_o,
    output logic [INDEX_WIDTH-1:0]  index_o,
    output logic [OFFSET_WIDTH-1:0] offset_o
);

    assign offset_o = addr_i[OFFSET_WIDTH-1:0];
    assign index_o  = addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag_o    = addr_i[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];

endmodule

// File: rtl/cache_controller.sv
// Blocking write-back / write-allocate controller sitting in front of cache_memory.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_controller
    import cache_pkg::*;
#(
    parameter int WORD_SIZE       = DEF_WORD_SIZE,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int NUM_BLOCKS      = DEF_NUM_BLOCKS,
    parameter int NUM_WAYS        = DEF_NUM_WAYS,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    localparam int NUM_SETS       = sets_of(NUM_BLOCKS, NUM_WAYS),
    localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
    localparam int OFFSET_WIDTH   = offset_width(WORDS_PER_BLOCK),
    localparam int TAG_WIDTH      = tag_width(ADDR_WIDTH, NUM_BLOCKS, NUM_WAYS, WORDS_PER_BLOCK)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic                    cpu_req_type,
    input  logic [WORD_SIZE-1:0]    cpu_wdata,
    output logic                    cpu_done,
    output logic [TAG_WIDTH-1:0]    tag,
    output logic [INDEX_WIDTH-1:0]  index,
    output logic [OFFSET_WIDTH-1:0] blk_offset,
    output logic                    req_type,
    output logic [WORD_SIZE-1:0]    data_in,
    output logic                    read_en_cache,
    output logic                    write_en_cache,
    output logic                    read_en_mem,
    output logic                    write_en_mem,
    input  logic                    hit,
    input  logic                    dirty_bit,
    output logic                    mem_req,
    output logic                    mem_we,
`ifdef CACHE_STATS_EN
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count,
`endif
    input  logic                    mem_ack
);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [INDEX_WIDTH-1:0]  index;
        logic [OFFSET_WIDTH-1:0] offset;
        logic                    wr;
        logic [WORD_SIZE-1:0]    wdata;
    } cpu_req_t;

    cache_state_e state_q;
    cpu_req_t     req_q;
    cpu_req_t     req_d;
    logic         cpu_ready_q;
    logic         cpu_done_q;
    logic         rd_cache_q;
    logic         wr_cache_q;
    logic         rd_mem_q;
    logic         wr_mem_q;
    logic         mem_req_q;
    logic         mem_we_q;

    cache_addr_split #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_split (
        .addr_i  (cpu_addr),
        .tag_o   (req_d.tag),
        .index_o (req_d.index),
        .offset_o(req_d.offset)
    );

    assign req_d.wr    = cpu_req_type;
    assign req_d.wdata = cpu_wdata;

    // Every output is a flop; hit/dirty_bit/mem_ack only steer next-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cpu_ready_q <= 1'b1;
            cpu_done_q  <= 1'b0;
            rd_cache_q  <= 1'b0;
            wr_cache_q  <= 1'b0;
            rd_mem_q    <= 1'b0;
            wr_mem_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            cpu_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_valid && cpu_ready_q) begin
                        req_q       <= req_d;
                        state_q     <= COMPARE;
                        cpu_ready_q <= 1'b0;
                        rd_cache_q  <= ~cpu_req_type;
                        wr_cache_q  <= cpu_req_type;
                    end
                end
                COMPARE: begin
                    rd_cache_q <= 1'b0;
                    wr_cache_q <= 1'b0;
                    if (hit) begin
                        state_q     <= IDLE;
                        cpu_done_q  <= 1'b1;
                        cpu_ready_q <= 1'b1;
                    end else if (dirty_bit) begin
                        state_q   <= WRITE_BACK;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        wr_mem_q  <= 1'b1;
                    end else begin
                        state_q   <= ALLOCATE;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                    end
                end
                WRITE_BACK: begin
                    // mem_req stays high: the fetch follows the write-back directly.
                    if (mem_ack) begin
                        state_q  <= ALLOCATE;
                        mem_we_q <= 1'b0;
                        wr_mem_q <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        state_q   <= REFILL;
                        mem_req_q <= 1'b0;
                        rd_mem_q  <= 1'b1;
                    end
                end
                REFILL: begin
                    state_q    <= COMPARE;
                    rd_mem_q   <= 1'b0;
                    rd_cache_q <= ~req_q.wr;
                    wr_cache_q <= req_q.wr;
                end
                default: begin
                    state_q     <= IDLE;
                    cpu_ready_q <= 1'b1;
                    rd_cache_q  <= 1'b0;
                    wr_cache_q  <= 1'b0;
                    rd_mem_q    <= 1'b0;
                    wr_mem_q    <= 1'b0;
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ready      = cpu_ready_q;
    assign cpu_done       = cpu_done_q;
    assign tag            = req_q.tag;
    assign index          = req_q.index;
    assign blk_offset     = req_q.offset;
    assign req_type       = req_q.wr;
    assign data_in        = req_q.wdata;
    assign read_en_cache  = rd_cache_q;
    assign write_en_cache = wr_cache_q;
    assign read_en_mem    = rd_mem_q;
    assign write_en_mem   = wr_mem_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;
    logic        retry_q;

    // A COMPARE that directly follows REFILL is the post-refill retry.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == COMPARE && !retry_q) begin
            if (hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            retry_q    <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            retry_q    <= (state_q == REFILL);
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    a_cache_en_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_cache_q && wr_cache_q));
    a_mem_en_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_mem_q && wr_mem_q));
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        cpu_ready_q == (state_q == IDLE));

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller with a behavioural cache_memory and memory model.
// Build with +define+CACHE_STATS_EN to also check the hit/miss counters.
`timescale 1ns/1ps
module tb_cache_controller;
    import cache_pkg::*;

    localparam int WS  = 32;
    localparam int WPB = 4;
    localparam int NB  = 64;
    localparam int NW  = 4;
    localparam int AW  = 32;
    localparam int NS  = NB / NW;
    localparam int IW  = $clog2(NS);
    localparam int OW  = $clog2(WPB);
    localparam int TW  = AW - IW - OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_valid;
    logic          cpu_ready;
    logic [AW-1:0] cpu_addr;
    logic          cpu_req_type;
    logic [WS-1:0] cpu_wdata;
    logic          cpu_done;
    logic [TW-1:0] tag;
    logic [IW-1:0] index;
    logic [OW-1:0] blk_offset;
    logic          req_type;
    logic [WS-1:0] data_in;
    logic          read_en_cache, write_en_cache, read_en_mem, write_en_mem;
    logic          hit, dirty_bit;
    logic          mem_req, mem_we, mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    cache_controller #(
        .WORD_SIZE(WS), .WORDS_PER_BLOCK(WPB), .NUM_BLOCKS(NB), .NUM_WAYS(NW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_addr(cpu_addr), .cpu_req_type(cpu_req_type), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .tag(tag), .index(index), .blk_offset(blk_offset),
        .req_type(req_type), .data_in(data_in), .read_en_cache(read_en_cache),
        .write_en_cache(write_en_cache), .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
        .hit(hit), .dirty_bit(dirty_bit), .mem_req(mem_req), .mem_we(mem_we),
`ifdef CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Behavioural cache_memory: tag store, data store, round-robin victim choice.
    logic          m_valid [NS][NW];
    logic          m_dirty [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];
    logic [WS-1:0] m_data  [NS][NW][WPB];
    int            m_rr    [NS];
    logic [WS-1:0] bmem [logic [AW-1:0]];
    // Reference: a flat word-addressed memory, what the CPU must observe.
    logic [WS-1:0] refm [logic [AW-1:0]];

    typedef struct {
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic          wr;
        logic [WS-1:0] wd;
        logic [WS-1:0] rd;
        logic          hit;
        logic          wb;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic hold_alloc = 1'b0;
    logic [WS-1:0] model_rdata;

    function automatic logic [WS-1:0] init_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [WS-1:0] bm_read(input logic [AW-1:0] a);
        return bmem.exists(a) ? bmem[a] : init_word(a);
    endfunction

    function automatic logic [WS-1:0] ref_read(input logic [AW-1:0] a);
        return refm.exists(a) ? refm[a] : init_word(a);
    endfunction

    function automatic int find_way(input logic [IW-1:0] s, input logic [TW-1:0] t);
        for (int w = 0; w < NW; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int victim(input logic [IW-1:0] s);
        for (int w = 0; w < NW; w++)
            if (!m_valid[s][w]) return w;
        return m_rr[s];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Environment: memory responder, cache_memory lookups and updates (negedge + 0).
    initial begin
        int way, vw;
        int ack_wait;
        logic [AW-1:0] a;
        ack_wait = 0;
        mem_ack = 1'b0; hit = 1'b0; dirty_bit = 1'b0; model_rdata = '0;
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_tag[s][w] = '0;
                for (int k = 0; k < WPB; k++) m_data[s][w][k] = '0;
            end
        end
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst_n && mem_req && !(hold_alloc && !mem_we)) begin
                if (ack_wait == 0) begin
                    mem_ack  = 1'b1;
                    ack_wait = $urandom_range(0, 5);
                end else ack_wait--;
            end else if (rst_n && !mem_req) begin
                mem_ack = ($urandom_range(0, 15) == 0);
            end
            way = find_way(index, tag);
            vw  = victim(index);
            hit = (way >= 0);
            dirty_bit = m_valid[index][vw] && m_dirty[index][vw];
            model_rdata = (way >= 0) ? m_data[index][way][blk_offset] : '0;
            if (rst_n && write_en_cache && way >= 0) begin
                m_data[index][way][blk_offset] = data_in;
                m_dirty[index][way] = 1'b1;
            end
            if (rst_n && write_en_mem && mem_ack) begin
                for (int k = 0; k < WPB; k++) begin
                    a = {m_tag[index][vw], index, OW'(k)};
                    bmem[a] = m_data[index][vw][k];
                end
            end
            if (rst_n && read_en_mem) begin
                m_valid[index][vw] = 1'b1;
                m_dirty[index][vw] = 1'b0;
                m_tag[index][vw]   = tag;
                for (int k = 0; k < WPB; k++) m_data[index][vw][k] = bm_read({tag, index, OW'(k)});
                m_rr[index] = (vw + 1) % NW;
            end
        end
    end

    // Monitor: per-transaction activity counts, compared against the scoreboard on cpu_done.
    initial begin
        int cyc, lk, wbh, alh, rf, mrq;
        exp_t e;
        cyc = 0; lk = 0; wbh = 0; alh = 0; rf = 0; mrq = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                cyc = 0; lk = 0; wbh = 0; alh = 0; rf = 0; mrq = 0;
                continue;
            end
            if (read_en_cache || write_en_cache)
                check("cache_en_excl", {read_en_cache, write_en_cache} == 2'b11, 0);
            if (read_en_mem || write_en_mem)
                check("mem_en_excl", {read_en_mem, write_en_mem} == 2'b11, 0);
            if (mem_req || write_en_mem) check("wb_en_matches_we", write_en_mem, mem_req && mem_we);
            if (sb.size() == 0) begin
                cyc = 0; lk = 0; wbh = 0; alh = 0; rf = 0; mrq = 0;
                if (mem_req || read_en_cache || write_en_cache || read_en_mem || cpu_done)
                    check("idle_quiet", {mem_req, read_en_cache, write_en_cache, read_en_mem, cpu_done}, 0);
            end else begin
                cyc++;
                if (read_en_cache || write_en_cache) lk++;
                if (read_en_mem) rf++;
                if (mem_req) mrq++;
                if (mem_req && mem_ack) begin
                    if (mem_we) wbh++; else alh++;
                end
                if (cpu_done) begin
                    e = sb.pop_front();
                    check("latency", cyc, e.hit ? 2 : mrq + 4);
                    check("lookups", lk, e.hit ? 1 : 2);
                    check("refills", rf, e.hit ? 0 : 1);
                    check("wb_handshakes", wbh, (!e.hit && e.wb) ? 1 : 0);
                    check("alloc_handshakes", alh, e.hit ? 0 : 1);
                    check("fields", {tag, index, blk_offset, req_type}, {e.tag, e.idx, e.off, e.wr});
                    if (e.wr) check("data_in", data_in, e.wd);
                    else      check("read_data", model_rdata, e.rd);
                    cyc = 0; lk = 0; wbh = 0; alh = 0; rf = 0; mrq = 0;
                end else if (cyc > 300) begin
                    check("done_timeout", 0, 1);
                    void'(sb.pop_front());
                    cyc = 0; lk = 0; wbh = 0; alh = 0; rf = 0; mrq = 0;
                end
            end
        end
    end

    // Called at negedge + 2 while cpu_ready is high: predicts and drives one request.
    task automatic issue(input logic [TW-1:0] t, input logic [IW-1:0] ix,
                         input logic [OW-1:0] of, input logic wr, input logic [WS-1:0] wd);
        exp_t e;
        logic [AW-1:0] a;
        int vw;
        a = {t, ix, of};
        vw = victim(ix);
        e.tag = t; e.idx = ix; e.off = of; e.wr = wr; e.wd = wd;
        e.hit = (find_way(ix, t) >= 0);
        e.wb  = m_valid[ix][vw] && m_dirty[ix][vw];
        e.rd  = ref_read(a);
        if (wr) refm[a] = wd;
        if (e.hit) exp_hits++; else exp_miss++;
        cpu_valid = 1'b1; cpu_addr = a; cpu_req_type = wr; cpu_wdata = wd;
        sb.push_back(e);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((sb.size() != 0 || !cpu_ready) && n < 1000) begin
            @(negedge clk); #2;
            cpu_valid = 1'b0;
            n++;
        end
        if (n >= 1000) check("drain_timeout", 0, 1);
    endtask

    task automatic run_random(input int count);
        int issued, cycles;
        issued = 0; cycles = 0;
        while (issued < count && cycles < 20000) begin
            @(negedge clk); #2;
            cycles++;
            if (cpu_ready && sb.size() == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    issue(TW'($urandom_range(0, 7)), IW'($urandom_range(0, 3)),
                          OW'($urandom_range(0, WPB-1)), 1'($urandom_range(0, 1)), $urandom);
                    issued++;
                end else cpu_valid = 1'b0;
            end else begin
                // Noise on the CPU side while busy must be ignored.
                cpu_valid = 1'($urandom_range(0, 1));
                cpu_addr = $urandom; cpu_req_type = 1'($urandom_range(0, 1)); cpu_wdata = $urandom;
            end
        end
        wait_drained();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int n;
        rst_n = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_req_type = 1'b0; cpu_wdata = '0;
        @(negedge clk); #2;
        check("rst_cpu_ready", cpu_ready, 1);
        check("rst_cpu_done", cpu_done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_enables", {read_en_cache, write_en_cache, read_en_mem, write_en_mem}, 0);
        check("rst_fields", {tag, index, blk_offset, req_type}, 0);
        check("rst_data_in", data_in, 0);
`ifdef CACHE_STATS_EN
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
`endif
        #1 rst_n = 1'b1;

        // Preload set 0 way 0 with a clean line for the directed hit cases.
        for (int k = 0; k < WPB; k++) begin
            a = {26'h1ABCDE, 4'd0, OW'(k)};
            m_data[0][0][k] = (k == 2) ? 32'hCCCC1111 : 32'h1111_0000 + k;
            bmem[a] = m_data[0][0][k];
            refm[a] = m_data[0][0][k];
        end
        m_valid[0][0] = 1'b1; m_dirty[0][0] = 1'b0; m_tag[0][0] = 26'h1ABCDE;

        @(negedge clk); #2;
        issue(26'h1ABCDE, 4'd0, 2'd2, 1'b0, '0);
        wait_drained();
        @(negedge clk); #2;
        issue(26'h1ABCDE, 4'd0, 2'd2, 1'b1, 32'h0BADF00D);
        wait_drained();
        @(negedge clk); #2;
        issue(26'h1ABCDE, 4'd0, 2'd2, 1'b0, '0);
        wait_drained();
        @(negedge clk); #2;
        issue(26'h2000, 4'd3, 2'd1, 1'b0, '0);
        wait_drained();

        run_random(300);

        // Reset while ALLOCATE is waiting for its ack.
        hold_alloc = 1'b1;
        @(negedge clk); #2;
        issue(26'h3F_0000, 4'd2, 2'd0, 1'b0, '0);
        @(negedge clk); #2;
        cpu_valid = 1'b0;
        n = 0;
        while (!(mem_req && !mem_we) && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        check("reach_allocate", mem_req && !mem_we, 1);
        #1 rst_n = 1'b0;
        sb.delete();
        exp_hits = 0; exp_miss = 0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_cpu_ready", cpu_ready, 1);
        check("arst_enables", {read_en_cache, write_en_cache, read_en_mem, write_en_mem, mem_we}, 0);
        check("arst_fields", {tag, index, blk_offset}, 0);
        hold_alloc = 1'b0;
        @(negedge clk); #3 rst_n = 1'b1;

        @(negedge clk); #2;
        issue(26'h3F_0000, 4'd2, 2'd0, 1'b0, '0);
        wait_drained();
        run_random(60);

`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_miss);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
